ddr_frame_sequencer: RTL and testbench

- Sequences one HDR-DDR transaction over the shared SCL-edge bit counter: command word, then N data words, then the CRC word.
- Drives the bit counter enable and consumes its count to detect word boundaries.
- Tells the serializer/deserializer which word type is active, which data index is active, and whether the controller drives SDA.
- Sits between the transaction FSM (start/abort) and the bit counter / SDA datapath.

---
 rtl/ddr_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_ddr_frame_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_sequencer.sv
// HDR-DDR frame sequencer: walks CMD, N DATA words and CRC over the shared
// SCL-edge bit counter, steering the SDA datapath word by word.
module ddr_frame_sequencer #(
  parameter int MAX_WORDS = 8,
  parameter int WCNT_W    = 4
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rnw,
  input  logic [WCNT_W-1:0] i_data_len,
  input  logic              i_abort,
  input  logic              i_scl_pos_edge,
  input  logic              i_scl_neg_edge,
  input  logic [5:0]        i_bit_count,
  output logic              o_bitcnt_en,
  output logic [1:0]        o_word_sel,
  output logic [WCNT_W-1:0] o_word_idx,
  output logic              o_word_req,
  output logic              o_sda_drive,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_CRC, S_DONE} state_t;

  localparam logic [1:0]        SEL_NONE = 2'b00;
  localparam logic [1:0]        SEL_CMD  = 2'b01;
  localparam logic [1:0]        SEL_DATA = 2'b10;
  localparam logic [1:0]        SEL_CRC  = 2'b11;
  localparam logic [WCNT_W-1:0] MAX_LEN  = WCNT_W'(MAX_WORDS);

  state_t            r_state;
  logic              r_rnw;
  logic [WCNT_W-1:0] r_len;
  logic              r_bitcnt_en;
  logic [1:0]        r_word_sel;
  logic [WCNT_W-1:0] r_word_idx;
  logic              r_word_req;
  logic              r_sda_drive;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_edge;
  logic              w_word_end;
  logic              w_crc_end;
  logic              w_last_end;
  logic [WCNT_W-1:0] w_len_clamped;

  // Both strobes in one cycle are a single edge.
  assign w_edge        = i_scl_pos_edge | i_scl_neg_edge;
  assign w_word_end    = w_edge && (i_bit_count == 6'd19);
  assign w_crc_end     = w_edge && (i_bit_count == 6'd9);
  assign w_last_end    = ((r_state == S_CMD) && w_word_end && (r_len == '0)) ||
                         ((r_state == S_CRC) && w_crc_end);
  assign w_len_clamped = (i_data_len > MAX_LEN) ? MAX_LEN : i_data_len;

  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values, regardless of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rnw       <= 1'b0;
      r_len       <= '0;
      r_bitcnt_en <= 1'b0;
      r_word_sel  <= SEL_NONE;
      r_word_idx  <= '0;
      r_word_req  <= 1'b0;
      r_sda_drive <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_word_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_word_idx <= '0;
          r_done     <= 1'b0;
          r_aborted  <= 1'b0;
          if (i_start && !i_abort) begin
            r_state     <= S_CMD;
            r_rnw       <= i_rnw;
            r_len       <= w_len_clamped;
            r_bitcnt_en <= 1'b1;
            r_word_sel  <= SEL_CMD;
            r_sda_drive <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_CMD, S_DATA, S_CRC: begin
          // Abort shares the finish path and wins over a coincident word end.
          if (i_abort || w_last_end) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_aborted   <= i_abort;
            r_bitcnt_en <= 1'b0;
            r_busy      <= 1'b0;
            r_word_sel  <= SEL_NONE;
            r_sda_drive <= 1'b0;
          end else if ((r_state == S_CMD) && w_word_end) begin
            r_state     <= S_DATA;
            r_word_sel  <= SEL_DATA;
            r_sda_drive <= !r_rnw;
            r_word_idx  <= '0;
            r_word_req  <= 1'b1;
          end else if ((r_state == S_DATA) && w_word_end) begin
            if (r_word_idx == r_len - WCNT_W'(1)) begin
              r_state    <= S_CRC;
              r_word_sel <= SEL_CRC;
            end else begin
              r_word_idx <= r_word_idx + WCNT_W'(1);
              r_word_req <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_aborted  <= 1'b0;
          r_word_idx <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bitcnt_en = r_bitcnt_en;
  assign o_word_sel  = r_word_sel;
  assign o_word_idx  = r_word_idx;
  assign o_word_req  = r_word_req;
  assign o_sda_drive = r_sda_drive;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_ddr_frame_sequencer.sv
// Self-checking bench for ddr_frame_sequencer: word-position reference model,
// per-cycle output compare, directed frames and a randomized soak.
module tb_ddr_frame_sequencer;

  logic       i_sys_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_rnw;
  logic [3:0] i_data_len;
  logic       i_abort;
  logic       i_scl_pos_edge;
  logic       i_scl_neg_edge;
  logic [5:0] i_bit_count;
  logic       o_bitcnt_en;
  logic [1:0] o_word_sel;
  logic [3:0] o_word_idx;
  logic       o_word_req;
  logic       o_sda_drive;
  logic       o_busy;
  logic       o_done;
  logic       o_aborted;

  ddr_frame_sequencer #(.MAX_WORDS(8), .WCNT_W(4)) dut (
    .i_sys_clk      (i_sys_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_rnw          (i_rnw),
    .i_data_len     (i_data_len),
    .i_abort        (i_abort),
    .i_scl_pos_edge (i_scl_pos_edge),
    .i_scl_neg_edge (i_scl_neg_edge),
    .i_bit_count    (i_bit_count),
    .o_bitcnt_en    (o_bitcnt_en),
    .o_word_sel     (o_word_sel),
    .o_word_idx     (o_word_idx),
    .o_word_req     (o_word_req),
    .o_sda_drive    (o_sda_drive),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_aborted      (o_aborted)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a list of words (0 = CMD, 1..len = DATA,
  // len+1 = CRC when len > 0); m_word is the position in that list, -1 = none.
  int m_word = -1;
  int m_len  = 0;
  int m_idx  = 0;
  bit m_rnw  = 1'b0;
  bit m_fin  = 1'b0;
  bit m_ab   = 1'b0;
  bit m_req  = 1'b0;
  int cnt_n  = 0;

  always @(posedge i_sys_clk) begin
    logic e;
    int   end_at;
    e = i_scl_pos_edge | i_scl_neg_edge;
    // External bit counter: cleared while disabled, wraps 19 -> 0.
    if (m_word < 0)  cnt_n = 0;
    else if (e)      cnt_n = (i_bit_count == 6'd19) ? 0 : int'(i_bit_count) + 1;
    else             cnt_n = int'(i_bit_count);
    m_req = 1'b0;
    if (!i_rst_n) begin
      m_word = -1; m_fin = 1'b0; m_ab = 1'b0; m_idx = 0; m_len = 0; m_rnw = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0; m_ab = 1'b0; m_idx = 0;
    end else if (m_word < 0) begin
      if (i_start && !i_abort) begin
        m_word = 0; m_rnw = i_rnw; m_idx = 0;
        m_len  = (i_data_len > 4'd8) ? 8 : int'(i_data_len);
      end
    end else if (i_abort) begin
      m_word = -1; m_fin = 1'b1; m_ab = 1'b1;
    end else begin
      end_at = (m_word == m_len + 1) ? 9 : 19;
      if (e && int'(i_bit_count) == end_at) begin
        if ((m_word == 0 && m_len == 0) || m_word == m_len + 1) begin
          m_word = -1; m_fin = 1'b1;
        end else begin
          m_word++;
          if (m_word <= m_len) begin
            m_req = 1'b1;
            m_idx = m_word - 1;
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_pack();
    logic [1:0] sel;
    logic       sda;
    if (m_word < 0)           sel = 2'b00;
    else if (m_word == 0)     sel = 2'b01;
    else if (m_word <= m_len) sel = 2'b10;
    else                      sel = 2'b11;
    sda = (m_word == 0) ? 1'b1 : ((m_word > 0) ? !m_rnw : 1'b0);
    return {20'b0, (m_word >= 0), sel, 4'(m_idx), m_req, sda, (m_word >= 0), m_fin, m_ab};
  endfunction

  function automatic logic [31:0] act_pack();
    return {20'b0, o_bitcnt_en, o_word_sel, o_word_idx, o_word_req, o_sda_drive,
            o_busy, o_done, o_aborted};
  endfunction

  always @(negedge i_sys_clk) begin
    if (cmp_on) check("outputs", act_pack(), exp_pack());
  end

  task automatic set_inputs(input logic rst, input logic st, input logic rnw,
                            input logic [3:0] len, input logic ab, input logic ed,
                            input logic [5:0] bc);
    int k;
    i_rst_n = rst; i_start = st; i_rnw = rnw; i_data_len = len;
    i_abort = ab;  i_bit_count = bc;
    if (ed) begin
      k = int'($urandom_range(0, 2));
      i_scl_pos_edge = (k != 1);
      i_scl_neg_edge = (k != 0);
    end else begin
      i_scl_pos_edge = 1'b0;
      i_scl_neg_edge = 1'b0;
    end
  endtask

  // Per-frame observations gathered by run_txn.
  int t_reqs, t_last_idx, t_done, t_ab, t_idx_done, t_gap, t_sda_low, t_dc, t_crc_lat;

  task automatic run_txn(input logic rnw, input logic [3:0] len, input int period,
                         input int abort_word);
    logic ed, ab_now;
    int   crc_cyc;
    t_reqs = 0; t_last_idx = -1; t_done = 0; t_ab = -1; t_idx_done = -1;
    t_gap = 0; t_sda_low = 0; t_dc = 0; t_crc_lat = -1; crc_cyc = -1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_sys_clk);
      if (c > 0) begin
        if (o_word_req) begin t_reqs++; t_last_idx = int'(o_word_idx); end
        if (o_busy && !o_bitcnt_en) t_gap++;
        if (o_busy && !o_sda_drive) t_sda_low++;
        if (o_word_sel[1]) t_dc++;
        if (o_done) begin
          t_done = 1; t_ab = int'(o_aborted); t_idx_done = int'(o_word_idx);
          if (crc_cyc >= 0) t_crc_lat = c - crc_cyc;
          break;
        end
      end
      ed = (c > 0) && (c % period == 0);
      if (ed && o_word_sel == 2'b11 && cnt_n == 9) crc_cyc = c;
      ab_now = (abort_word >= 0) && ed && (m_word == abort_word) && (cnt_n == 19);
      set_inputs(1'b1, (c == 0), rnw, len, ab_now, ed, 6'(cnt_n));
    end
    check("txn_done_seen", t_done, 1);
  endtask

  initial begin
    logic       rr, st, ab, ed;
    logic [5:0] bc;
    set_inputs(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 6'd19);
    @(posedge i_sys_clk);
    cmp_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_sys_clk);
      check("reset_outputs_zero", act_pack(), 32'h0);
      set_inputs(1'b0, i[0], !i[0], 4'(i + 3), !i[0], i[0], 6'(i * 5));
    end
    @(negedge i_sys_clk);
    set_inputs(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 6'd0);
    @(negedge i_sys_clk);
    check("start_in_reset_ignored", {31'b0, o_busy}, 32'h0);

    // Write, two data words, edge every 4 clocks.
    run_txn(1'b0, 4'd2, 4, -1);
    check("w2_req_count",  t_reqs, 2);
    check("w2_last_idx",   t_last_idx, 1);
    check("w2_aborted",    t_ab, 0);
    check("w2_sda_low",    t_sda_low, 0);
    check("w2_en_gap",     t_gap, 0);
    check("w2_crc_to_done", t_crc_lat, 1);

    // Read, one data word.
    run_txn(1'b1, 4'd1, 2, -1);
    check("r1_req_count",  t_reqs, 1);
    check("r1_crc_to_done", t_crc_lat, 1);
    check("r1_sda_low_cycles_nonzero", {31'b0, (t_sda_low > 0)}, 32'h1);

    // Zero-length frame.
    run_txn(1'b0, 4'd0, 1, -1);
    check("l0_req_count",  t_reqs, 0);
    check("l0_data_crc",   t_dc, 0);
    check("l0_aborted",    t_ab, 0);

    // Oversize length clamps to 8.
    run_txn(1'b0, 4'd12, 1, -1);
    check("l12_req_count", t_reqs, 8);
    check("l12_last_idx",  t_last_idx, 7);

    // Abort on the word end of DATA idx 1.
    run_txn(1'b0, 4'd4, 3, 2);
    check("ab_aborted",    t_ab, 1);
    check("ab_idx_held",   t_idx_done, 1);
    check("ab_req_count",  t_reqs, 2);

    // A fresh start after the abort is accepted.
    run_txn(1'b1, 4'd0, 2, -1);
    check("post_abort_aborted", t_ab, 0);

    // Randomized soak against the model.
    for (int i = 0; i < 20000; i++) begin
      @(negedge i_sys_clk);
      rr = ($urandom_range(0, 2999) != 0);
      st = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 399) == 0);
      ed = ($urandom_range(0, 1) == 1);
      bc = ($urandom_range(0, 31) == 0) ? 6'($urandom_range(0, 19)) : 6'(cnt_n);
      set_inputs(rr, st, 1'($urandom), 4'($urandom_range(0, 15)), ab, ed, bc);
    end
    @(negedge i_sys_clk);
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
